// File: rtl/scalar_bank_arb_if.sv
// scalar_bank_arb_if: requester-side bus of the scalar bank arbiter.
// Per-requester request fields in, grant and read return out.
interface scalar_bank_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 16
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         req_we;
  logic [NREQ-1:0][1:0]    req_len;
  logic [NREQ-1:0][AW-1:0] req_adr;
  logic [NREQ-1:0][DW-1:0] req_din;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         rvalid;
  logic [NREQ-1:0][DW-1:0] rdata;

  modport master (
    output req, req_we, req_len, req_adr, req_din,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_len, req_adr, req_din,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/scalar_bank_arb.sv
// scalar_bank_arb: round-robin arbiter sharing one dual-port
// scalar bank among NREQ requesters, 1-cycle read return.
package xmem_param_pkg;
  localparam int XMEM_AW = 16;
endpackage

module scalar_bank_arb
  import xmem_param_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  scalar_bank_arb_if.slave   rq,
  output logic               bk_we0,
  output logic               bk_we1,
  output logic [1:0]         bk_len0,
  output logic [1:0]         bk_len1,
  output logic [XMEM_AW-1:0] bk_adr0,
  output logic [XMEM_AW-1:0] bk_adr1,
  output logic [DW-1:0]      bk_din0,
  output logic [DW-1:0]      bk_din1,
  input  logic [DW-1:0]      bk_dout0,
  input  logic [DW-1:0]      bk_dout1
);
  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0] NR = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ-1);

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] own0_q, own0_d;
  logic [PW-1:0] own1_q, own1_d;
  logic          rd0_q, rd0_d;
  logic          rd1_q, rd1_d;

  logic          v0, v1;
  logic [PW-1:0] p0, p1;
  logic [PW-1:0] lastg;

  // Scan from rr_q with wrap: first hit to port 0,
  // next hit not clashing on the same word to port 1
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          clash;
    v0    = 1'b0;
    v1    = 1'b0;
    p0    = '0;
    p1    = '0;
    sum   = '0;
    idx   = '0;
    clash = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (PW+1)'(k);
      if (sum >= NR) sum = sum - NR;
      idx = sum[PW-1:0];
      clash = (rq.req_adr[p0][XMEM_AW-1:2] ==
               rq.req_adr[idx][XMEM_AW-1:2]) &&
              (rq.req_we[p0] | rq.req_we[idx]);
      if (!rst && rq.req[idx]) begin
        if (!v0) begin
          v0 = 1'b1;
          p0 = idx;
        end else if (!v1 && !clash) begin
          v1 = 1'b1;
          p1 = idx;
        end
      end
    end
  end

  // Same-cycle grant vector, one bit per winner
  always_comb begin
    rq.gnt = '0;
    if (v0) rq.gnt[p0] = 1'b1;
    if (v1) rq.gnt[p1] = 1'b1;
  end

  // Route winning request fields to bank ports; idle port is zero
  always_comb begin
    bk_we0  = 1'b0;
    bk_len0 = '0;
    bk_adr0 = '0;
    bk_din0 = '0;
    bk_we1  = 1'b0;
    bk_len1 = '0;
    bk_adr1 = '0;
    bk_din1 = '0;
    if (v0) begin
      bk_we0  = rq.req_we[p0];
      bk_len0 = rq.req_len[p0];
      bk_adr0 = rq.req_adr[p0];
      bk_din0 = rq.req_din[p0];
    end
    if (v1) begin
      bk_we1  = rq.req_we[p1];
      bk_len1 = rq.req_len[p1];
      bk_adr1 = rq.req_adr[p1];
      bk_din1 = rq.req_din[p1];
    end
  end

  // Pointer moves past the last winner; remember read owners
  always_comb begin
    lastg  = v1 ? p1 : p0;
    rr_d   = rr_q;
    if (v0) rr_d = (lastg == LAST) ? '0 : lastg + 1'b1;
    own0_d = p0;
    own1_d = p1;
    rd0_d  = v0 & ~rq.req_we[p0];
    rd1_d  = v1 & ~rq.req_we[p1];
  end

  // Return bank data to the requester that owned each port
  always_comb begin
    rq.rvalid = '0;
    rq.rdata  = '0;
    if (rd0_q && !rst) begin
      rq.rvalid[own0_q] = 1'b1;
      rq.rdata[own0_q]  = bk_dout0;
    end
    if (rd1_q && !rst) begin
      rq.rvalid[own1_q] = 1'b1;
      rq.rdata[own1_q]  = bk_dout1;
    end
  end

  // State registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= '0;
      own0_q <= '0;
      own1_q <= '0;
      rd0_q  <= 1'b0;
      rd1_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      own0_q <= own0_d;
      own1_q <= own1_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
    end
  end
endmodule

// File: tb/tb_scalar_bank_arb.sv
// tb_scalar_bank_arb: directed scenarios plus random traffic
// against a byte-memory reference and a queue scoreboard.
module tb_scalar_bank_arb;
  import xmem_param_pkg::*;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = XMEM_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scalar_bank_arb_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) rq ();

  logic          bk_we0, bk_we1;
  logic [1:0]    bk_len0, bk_len1;
  logic [AW-1:0] bk_adr0, bk_adr1;
  logic [DW-1:0] bk_din0, bk_din1;
  logic [DW-1:0] bk_dout0 = '0;
  logic [DW-1:0] bk_dout1 = '0;

  scalar_bank_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst(rst), .rq(rq),
    .bk_we0(bk_we0), .bk_we1(bk_we1),
    .bk_len0(bk_len0), .bk_len1(bk_len1),
    .bk_adr0(bk_adr0), .bk_adr1(bk_adr1),
    .bk_din0(bk_din0), .bk_din1(bk_din1),
    .bk_dout0(bk_dout0), .bk_dout1(bk_dout1)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q [NREQ][$];
  logic [7:0] ref_mem [256];
  logic [7:0] bnk_mem [256];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int m_rr = 0;
  int wait_c [NREQ];
  bit wchk_en = 1'b0;
  logic [NREQ-1:0] gnt_s = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a,
                                           input logic [1:0] l,
                                           input bit bank);
    logic [DW-1:0] v;
    logic [7:0] p;
    v = '0;
    for (int b = 0; b < 4; b++) begin
      p = a[7:0] + 8'(b);
      if (b <= int'(l)) v[8*b +: 8] = bank ? bnk_mem[p] : ref_mem[p];
    end
    return v;
  endfunction

  // Bank stand-in: byte memory, read data one cycle after address
  always @(posedge clk) begin
    bk_dout0 <= mem_rd(bk_adr0, bk_len0, 1'b1);
    bk_dout1 <= mem_rd(bk_adr1, bk_len1, 1'b1);
    for (int b = 0; b < 4; b++) begin
      if (bk_we0 && b <= int'(bk_len0))
        bnk_mem[bk_adr0[7:0] + 8'(b)] <= bk_din0[8*b +: 8];
      if (bk_we1 && b <= int'(bk_len1))
        bnk_mem[bk_adr1[7:0] + 8'(b)] <= bk_din1[8*b +: 8];
    end
  end

  function automatic bit clash(input int a, input int b);
    return (rq.req_adr[a][AW-1:2] == rq.req_adr[b][AW-1:2]) &&
           (rq.req_we[a] || rq.req_we[b]);
  endfunction

  // Reference arbitration: ordered candidate list from the pointer
  function automatic logic [NREQ-1:0] ref_arb(input logic [NREQ-1:0] r,
                                              input int ptr,
                                              output int last);
    int cand[$];
    logic [NREQ-1:0] g;
    g = '0;
    last = -1;
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) cand.push_back((ptr + k) % NREQ);
    if (cand.size() > 0) begin
      g[cand[0]] = 1'b1;
      last = cand[0];
      for (int j = 1; j < cand.size(); j++) begin
        if (!clash(cand[0], cand[j])) begin
          g[cand[j]] = 1'b1;
          last = cand[j];
          break;
        end
      end
    end
    return g;
  endfunction

  // Reference model: predicts grants, queues expected read data
  initial begin : model
    logic [NREQ-1:0] eg;
    int last;
    exp_t e;
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    forever begin
      @(negedge clk);
      gnt_s = rq.gnt;
      if (rst) begin
        chk("gnt_in_rst", rq.gnt, 0);
        chk("bk_we_in_rst", {bk_we0, bk_we1}, 0);
        m_rr = 0;
        for (int i = 0; i < NREQ; i++) begin
          exp_q[i].delete();
          wait_c[i] = 0;
        end
      end else begin
        eg = ref_arb(rq.req, m_rr, last);
        chk("gnt", rq.gnt, eg);
        for (int i = 0; i < NREQ; i++)
          if (eg[i] && !rq.req_we[i]) begin
            e.cyc  = cyc;
            e.data = mem_rd(rq.req_adr[i], rq.req_len[i], 1'b0);
            exp_q[i].push_back(e);
          end
        for (int i = 0; i < NREQ; i++)
          if (eg[i] && rq.req_we[i])
            for (int b = 0; b <= int'(rq.req_len[i]); b++)
              ref_mem[rq.req_adr[i][7:0] + 8'(b)] = rq.req_din[i][8*b +: 8];
        if (last >= 0) m_rr = (last + 1) % NREQ;
        if ($countones(rq.gnt) == 2) begin
          n_chk++;
          if (bk_adr0[AW-1:2] == bk_adr1[AW-1:2] && (bk_we0 || bk_we1)) begin
            n_err++;
            $display("FAIL port_clash: word 0x%0h on both ports, we=%b%b",
                     bk_adr0[AW-1:2], bk_we0, bk_we1);
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (rq.gnt[i]) begin
            if (wchk_en) begin
              n_chk++;
              if (wait_c[i] > NREQ - 1) begin
                n_err++;
                $display("FAIL wait_bound req%0d: waited %0d, limit %0d",
                         i, wait_c[i], NREQ - 1);
              end
            end
            wait_c[i] = 0;
          end else if (rq.req[i]) begin
            wait_c[i]++;
          end
        end
      end
    end
  end

  // Monitor: pops an expectation whenever a requester sees rvalid
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rst) begin
          chk("rvalid_in_rst", rq.rvalid[i], 0);
        end else if (rq.rvalid[i]) begin
          if (exp_q[i].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL spurious_rvalid req%0d: got 1, required 0", i);
          end else begin
            e = exp_q[i].pop_front();
            chk("read_latency", cyc, e.cyc + 1);
            chk("rdata", rq.rdata[i], e.data);
          end
        end else begin
          chk("rdata_idle", rq.rdata[i], 0);
          if (exp_q[i].size() > 0 && exp_q[i][0].cyc + 1 < cyc) begin
            e = exp_q[i].pop_front();
            n_chk++;
            n_err++;
            $display("FAIL missing_rvalid req%0d: got 0, required 1", i);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    rq.req     = '0;
    rq.req_we  = '0;
    rq.req_len = '0;
    rq.req_adr = '0;
    rq.req_din = '0;
  endtask

  task automatic set_rq(input int i, input bit we, input logic [1:0] l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq.req[i]     = 1'b1;
    rq.req_we[i]  = we;
    rq.req_len[i] = l;
    rq.req_adr[i] = a;
    rq.req_din[i] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cyc_chk(input logic [NREQ-1:0] eg,
                         input logic [NREQ-1:0] ev, input string nm);
    @(negedge clk);
    chk({nm, "_gnt"}, rq.gnt, eg);
    chk({nm, "_rvalid"}, rq.rvalid, ev);
    tick();
  endtask

  task automatic new_req(input int i, input bit shared);
    int w, off, ls;
    logic [1:0] l;
    ls  = int'($urandom_range(0, 2));
    l   = (ls == 0) ? 2'd0 : (ls == 1) ? 2'd1 : 2'd3;
    off = (l == 2'd0) ? int'($urandom_range(0, 3)) :
          (l == 2'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
    w   = shared ? int'($urandom_range(0, 7))
                 : 8 * i + int'($urandom_range(0, 7));
    set_rq(i, 1'($urandom_range(0, 1)), l, AW'(w * 4 + off), $urandom);
  endtask

  initial begin : driver
    int gap [NREQ];
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = 8'h00;
      bnk_mem[a] = 8'h00;
    end
    clr_all();
    do_reset();

    for (int i = 0; i < NREQ; i++) set_rq(i, 1'b0, 2'd3, AW'(64 + 4 * i), '0);
    cyc_chk(4'b0011, 4'b0000, "rr_c0");
    cyc_chk(4'b1100, 4'b0011, "rr_c1");
    cyc_chk(4'b0011, 4'b1100, "rr_c2");
    clr_all();
    cyc_chk(4'b0000, 4'b0011, "rr_tail");

    do_reset();
    set_rq(0, 1'b1, 2'd3, AW'('h10), 32'hDEADBEEF);
    set_rq(1, 1'b0, 2'd0, AW'('h13), '0);
    cyc_chk(4'b0001, 4'b0000, "wr_conflict");
    rq.req[0] = 1'b0;
    cyc_chk(4'b0010, 4'b0000, "rd_after_wr");
    clr_all();
    @(negedge clk);
    chk("byte_rd_rvalid", rq.rvalid, 4'b0010);
    chk("byte_rd_data", rq.rdata[1], 32'h0000_00DE);
    tick();

    do_reset();
    set_rq(0, 1'b1, 2'd3, AW'('h20), 32'h1234_5678);
    set_rq(1, 1'b0, 2'd3, AW'('h04), '0);
    cyc_chk(4'b0011, 4'b0000, "pre_rr2");
    clr_all();
    set_rq(2, 1'b0, 2'd3, AW'('h20), '0);
    set_rq(3, 1'b0, 2'd3, AW'('h20), '0);
    cyc_chk(4'b1100, 4'b0010, "two_rd_same");
    clr_all();
    @(negedge clk);
    chk("two_rd_rvalid", rq.rvalid, 4'b1100);
    chk("two_rd_data2", rq.rdata[2], 32'h1234_5678);
    chk("two_rd_data3", rq.rdata[3], 32'h1234_5678);
    tick();

    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_rq(1, 1'b1, 2'd1, AW'('h30 + 2 * k), $urandom);
      @(negedge clk);
      chk("b2b_gnt", rq.gnt, 4'b0010);
      chk("b2b_we0", bk_we0, 1'b1);
      chk("b2b_we1", bk_we1, 1'b0);
      chk("b2b_adr0", bk_adr0, 'h30 + 2 * k);
      chk("b2b_adr1", bk_adr1, 0);
      tick();
    end

    do_reset();
    set_rq(2, 1'b0, 2'd3, AW'('h10), '0);
    cyc_chk(4'b0100, 4'b0000, "pre_rst_rd");
    clr_all();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_rvalid", rq.rvalid, 4'b0000);
    tick();
    rst = 1'b0;
    set_rq(3, 1'b0, 2'd3, AW'('h10), '0);
    cyc_chk(4'b1000, 4'b0000, "post_rst");
    clr_all();
    cyc_chk(4'b0000, 4'b1000, "post_rst_ret");

    do_reset();
    for (int i = 0; i < NREQ; i++) gap[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      wchk_en = (c < 5000);
      for (int i = 0; i < NREQ; i++) begin
        if (rq.req[i] && gnt_s[i]) begin
          rq.req[i] = 1'b0;
          gap[i] = int'($urandom_range(0, 2));
        end
        if (!rq.req[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if ($urandom_range(0, 3) != 0) new_req(i, c >= 5000);
        end
      end
      tick();
    end
    wchk_en = 1'b0;
    for (int c = 0; c < 200 && rq.req != '0; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (rq.req[i] && gnt_s[i]) rq.req[i] = 1'b0;
      tick();
    end
    chk("drain_idle", rq.req, 0);
    repeat (3) tick();
    for (int i = 0; i < NREQ; i++) chk("queue_empty", exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
